adc_spi_sampler: RTL
====================

ADC_SPI_SAMPLER -- requirements
Module: adc_spi_sampler

Interface
REQ-001 Parameter: CLK_DIV, default 4, meaning SCLK half-period in wb_clk_i cycles (legal range 2..255).
REQ-002 Parameter: SAMPLE_PERIOD, default 1000, meaning wb_clk_i cycles between conversion triggers (legal range 400..2^20-1).
REQ-003 wb_clk_i  input  1  system clock; sole clock of the block.
REQ-004 wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-005 enable  input  1  when high, the sample timer runs and triggers conversions.
REQ-006 adc_miso  input  1  serial data from the ADC.
REQ-007 adc_sclk  output  1  SPI clock to the ADC; idle low.
REQ-008 adc_cs_n  output  1  ADC chip select; active low.
REQ-009 adc_mosi  output  1  ADC command bits.
REQ-010 v_sample  output  12  last PV-voltage result (ADC channel 0), consumed by wrapped_mppt.
REQ-011 i_sample  output  12  last PV-current result (ADC channel 1), consumed by wrapped_mppt.
REQ-012 sample_valid  output  1  one-cycle pulse; v_sample and i_sample are updated in the same cycle.
REQ-013 busy  output  1  high from trigger until sample_valid, inclusive.
REQ-014 overrun  output  1  one-cycle pulse when a trigger is dropped because busy is high.

Function
REQ-015 Timer: counts 0..SAMPLE_PERIOD-1 while enable is high, then wraps; a trigger fires on the cycle the count equals SAMPLE_PERIOD-1; the timer holds at 0 while enable is low.
REQ-016 FSM states: IDLE, SETUP, SHIFT, GAP, DONE; one conversion is channel 0 then channel 1.
REQ-017 IDLE: on trigger, adc_cs_n falls the next cycle and the FSM goes to SETUP with ch=0.
REQ-018 SETUP: lasts CLK_DIV cycles with adc_sclk low, then SHIFT.
REQ-019 SHIFT frame: 17 SCLK periods, each period CLK_DIV cycles low then CLK_DIV cycles high.
REQ-020 adc_mosi: valid during the low phase of periods 1..4 with values 1 (start), 1 (single-ended), ch, 1 (MSB-first); 0 otherwise.
REQ-021 adc_miso: sampled on the cycle adc_sclk rises; period 5 (null bit) is ignored; periods 6..17 shift in data bits 11..0, MSB first.
REQ-022 End of frame: after period 17, adc_sclk returns low and adc_cs_n goes high. If ch=0, the FSM enters GAP for 2*CLK_DIV cycles, then SETUP with ch=1 and adc_cs_n low. If ch=1, the FSM enters DONE.
REQ-023 DONE: lasts one cycle. It loads v_sample and i_sample, pulses sample_valid, then returns to IDLE.
REQ-024 Latency: sample_valid is asserted exactly 72*CLK_DIV cycles after the trigger cycle (288 at default).
REQ-025 v_sample and i_sample hold their values between sample_valid pulses; they never show a partially shifted word.
REQ-026 A trigger while busy is dropped, pulses overrun, and does not disturb the conversion in progress.
REQ-027 enable falling mid-conversion: the current conversion completes normally and no further triggers occur.
REQ-028 A trigger coinciding with the DONE cycle is treated as busy (overrun).

Reset
REQ-029 While wb_rst_i is high, asynchronously: FSM=IDLE, timer=0, adc_cs_n=1, adc_sclk=0, adc_mosi=0, v_sample=0, i_sample=0, sample_valid=0, busy=0, overrun=0.
REQ-030 Reset asserted mid-frame aborts the frame immediately (adc_cs_n=1) and produces no sample_valid; after reset release, operation resumes from a timer count of 0.

Verification
REQ-031 Defaults, enable=1, ADC model returns 0xABC on ch0 and 0x123 on ch1 -> first trigger at cycle 999; sample_valid at trigger+288; v_sample=0xABC, i_sample=0x123.
REQ-032 Same setup, check MOSI bits -> frame 0 sends 1,1,0,1 and frame 1 sends 1,1,1,1; 17 SCLK rising edges per frame; adc_cs_n high for 8 cycles between frames.
REQ-033 SAMPLE_PERIOD=200 (test override), CLK_DIV=4 -> every second trigger asserts overrun for one cycle; sample_valid every 400 cycles; no corrupted data.
REQ-034 wb_rst_i pulse at trigger+100 -> adc_cs_n=1 within the pulse, no sample_valid, outputs=0, next trigger 1000 cycles after reset release.
REQ-035 enable dropped at trigger+50 -> sample_valid still at trigger+288, then no further adc_cs_n activity.
REQ-036 ADC model returns 0xFFF and 0x000 -> v_sample=0xFFF, i_sample=0x000 exactly (boundary values, bit order).

Source files
------------

// File: rtl/adc_spi_sampler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adc_spi_sampler                                                          |
// | Periodic two-channel 12-bit SPI ADC sampler (PV voltage, PV current).    |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module adc_spi_sampler #(
   parameter int CLK_DIV       = 4,
   parameter int SAMPLE_PERIOD = 1000
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        enable,
   input  logic        adc_miso,
   output logic        adc_sclk,
   output logic        adc_cs_n,
   output logic        adc_mosi,
   output logic [11:0] v_sample,
   output logic [11:0] i_sample,
   output logic        sample_valid,
   output logic        busy,
   output logic        overrun
);

   localparam int C_TMR_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam int C_DIV_W = 9;
   localparam logic [C_TMR_W-1:0] C_TMR_LAST = C_TMR_W'(SAMPLE_PERIOD - 1);
   localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(CLK_DIV - 1);
   localparam logic [C_DIV_W-1:0] C_GAP_LAST = C_DIV_W'(2 * CLK_DIV - 1);
   localparam logic [4:0]         C_BIT_LAST = 5'd16;
   localparam logic [4:0]         C_BIT_DATA = 5'd5;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_SHIFT = 3'd2,
      S_GAP   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [C_TMR_W-1:0]   r_timer;
   logic [C_DIV_W-1:0]   r_div;
   logic [C_DIV_W-1:0]   w_div_nxt;
   logic [4:0]           r_bit;
   logic [4:0]           w_bit_nxt;
   logic                 r_hi;
   logic                 w_hi_nxt;
   logic                 r_ch;
   logic                 w_ch_nxt;
   logic [11:0]          r_shreg;
   logic [11:0]          r_v_tmp;
   logic [11:0]          r_v;
   logic [11:0]          r_i;
   logic                 r_sclk;
   logic                 r_cs_n;
   logic                 r_mosi;
   logic                 w_sclk_nxt;
   logic                 w_cs_n_nxt;
   logic                 w_mosi_nxt;
   logic                 w_trigger;
   logic                 w_in_conv;
   logic                 w_sample_edge;

   assign w_trigger     = enable && (r_timer == C_TMR_LAST);
   assign w_in_conv     = (r_state != S_IDLE);
   assign w_sample_edge = (r_state == S_SHIFT) && r_hi && (r_div == '0);

   // Sample timer: free-runs while enabled, parked at zero otherwise.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_timer <= '0;
      end else if (!enable || (r_timer == C_TMR_LAST)) begin
         r_timer <= '0;
      end else begin
         r_timer <= r_timer + 1'b1;
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_state <= S_IDLE;
         r_div   <= '0;
         r_bit   <= '0;
         r_hi    <= 1'b0;
         r_ch    <= 1'b0;
         r_sclk  <= 1'b0;
         r_cs_n  <= 1'b1;
         r_mosi  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_div   <= w_div_nxt;
         r_bit   <= w_bit_nxt;
         r_hi    <= w_hi_nxt;
         r_ch    <= w_ch_nxt;
         r_sclk  <= w_sclk_nxt;
         r_cs_n  <= w_cs_n_nxt;
         r_mosi  <= w_mosi_nxt;
      end
   end

   // The trigger cycle counts as the first channel-0 setup cycle, which
   // places sample_valid exactly 72*CLK_DIV cycles after the trigger.
   always_comb begin
      w_state_nxt = r_state;
      w_div_nxt   = r_div;
      w_bit_nxt   = r_bit;
      w_hi_nxt    = r_hi;
      w_ch_nxt    = r_ch;
      case (r_state)
         S_IDLE: begin
            if (w_trigger) begin
               w_state_nxt = S_SETUP;
               w_div_nxt   = C_DIV_W'(1);
               w_ch_nxt    = 1'b0;
            end
         end
         S_SETUP: begin
            if (r_div == C_DIV_LAST) begin
               w_state_nxt = S_SHIFT;
               w_div_nxt   = '0;
               w_bit_nxt   = '0;
               w_hi_nxt    = 1'b0;
            end else begin
               w_div_nxt = r_div + 9'd1;
            end
         end
         S_SHIFT: begin
            if (r_div == C_DIV_LAST) begin
               w_div_nxt = '0;
               if (!r_hi) begin
                  w_hi_nxt = 1'b1;
               end else if (r_bit == C_BIT_LAST) begin
                  w_hi_nxt    = 1'b0;
                  w_state_nxt = r_ch ? S_DONE : S_GAP;
               end else begin
                  w_hi_nxt  = 1'b0;
                  w_bit_nxt = r_bit + 5'd1;
               end
            end else begin
               w_div_nxt = r_div + 9'd1;
            end
         end
         S_GAP: begin
            if (r_div == C_GAP_LAST) begin
               w_state_nxt = S_SETUP;
               w_div_nxt   = '0;
               w_ch_nxt    = 1'b1;
            end else begin
               w_div_nxt = r_div + 9'd1;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // Pin values are decoded from the next state and registered, so the
      // SPI pins never glitch.
      w_sclk_nxt = (w_state_nxt == S_SHIFT) && w_hi_nxt;
      w_cs_n_nxt = !((w_state_nxt == S_SETUP) || (w_state_nxt == S_SHIFT));
      w_mosi_nxt = 1'b0;
      if ((w_state_nxt == S_SHIFT) && !w_hi_nxt) begin
         case (w_bit_nxt)
            5'd0:    w_mosi_nxt = 1'b1;
            5'd1:    w_mosi_nxt = 1'b1;
            5'd2:    w_mosi_nxt = w_ch_nxt;
            5'd3:    w_mosi_nxt = 1'b1;
            default: w_mosi_nxt = 1'b0;
         endcase
      end
   end

   // Results are staged so the output words only change on sample_valid.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_shreg <= '0;
         r_v_tmp <= '0;
         r_v     <= '0;
         r_i     <= '0;
      end else begin
         if (w_sample_edge && (r_bit >= C_BIT_DATA)) begin
            r_shreg <= {r_shreg[10:0], adc_miso};
         end
         if ((r_state == S_SHIFT) && (w_state_nxt == S_GAP)) begin
            r_v_tmp <= r_shreg;
         end
         if ((r_state == S_SHIFT) && (w_state_nxt == S_DONE)) begin
            r_v <= r_v_tmp;
            r_i <= r_shreg;
         end
      end
   end

   assign adc_sclk     = r_sclk;
   assign adc_cs_n     = r_cs_n;
   assign adc_mosi     = r_mosi;
   assign v_sample     = r_v;
   assign i_sample     = r_i;
   assign sample_valid = (r_state == S_DONE);
   assign busy         = w_in_conv || w_trigger;
   assign overrun      = w_in_conv && w_trigger;

endmodule
`default_nettype wire
